// File: rtl/main_func_mul_share_arb.sv
// -----------------------------------------------------------------------------
// main_func_mul_share_arb
//
// Round-robin arbiter that time-shares one unsigned 7x9 -> 15-bit multiplier
// between NUM_REQ requesters. The granted operand pair is multiplied
// combinationally and the product is captured, together with the requester
// index, in a single output register.
//
// Ports:
//   ap_clk     in   clock, all state on the rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]      requester i has operands
//   req_ready  out  [NUM_REQ]      one-hot, requester i accepted this cycle
//   req_din0   in   [NUM_REQ*7]    packed 7-bit operand per requester
//   req_din1   in   [NUM_REQ*9]    packed 9-bit operand per requester
//   rsp_valid  out                 result register holds a product
//   rsp_ready  in                  consumer takes the result this cycle
//   rsp_dout   out  [15]           product, modulo 2^15
//   rsp_id     out  [ID_W]         requester that produced rsp_dout
//   op_cnt     out  [CNT_W]        accepted operations, wraps silently
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is a function of req_valid, rsp_valid, rsp_ready and the
// round-robin pointer; requesters must never make req_valid depend on
// req_ready. The result slot is free when it is empty or being drained in
// the same cycle, so back-to-back accepts run at one operation per cycle.
// -----------------------------------------------------------------------------
module main_func_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*7-1:0] req_din0,
  input  logic [NUM_REQ*9-1:0] req_din1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [14:0]          rsp_dout,
  output logic [ID_W-1:0]      rsp_id,
  output logic [CNT_W-1:0]     op_cnt
);

  localparam int ID_SPACE = 2 ** ID_W;

  logic                rsp_valid_q, rsp_valid_d;
  logic [14:0]         rsp_dout_q,  rsp_dout_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [CNT_W-1:0]    op_cnt_q,    op_cnt_d;

  logic                out_free;
  logic                accept;
  logic                found;
  logic [ID_W-1:0]     grant;
  logic [ID_W-1:0]     cand;
  logic [ID_SPACE-1:0] valid_ext;
  logic [6:0]          din0_sel;
  logic [8:0]          din1_sel;
  logic [15:0]         prod_full;
  int                  pos;

  // Widen req_valid to the full ID space so an ID_W-bit index is always legal.
  always_comb begin
    valid_ext = '0;
    valid_ext[NUM_REQ-1:0] = req_valid;
  end

  // Scan rr_ptr, rr_ptr+1, ... (mod NUM_REQ); first valid requester wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr_q) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = ID_W'(pos);
      if (!found && valid_ext[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // Gating with ap_rst_n keeps req_ready low while reset is held, even though
  // the empty result slot would otherwise look free.
  assign out_free = !rsp_valid_q || rsp_ready;
  assign accept   = ap_rst_n && out_free && (|req_valid);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (grant == ID_W'(i));
    end
  end

  // Operand mux driven by the granted index.
  always_comb begin
    din0_sel = '0;
    din1_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        din0_sel = req_din0[i*7 +: 7];
        din1_sel = req_din1[i*9 +: 9];
      end
    end
  end

  // Full 16-bit product; only the low 15 bits are kept (no saturation).
  assign prod_full = 16'(din0_sel) * 16'(din1_sel);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_dout_d  = rsp_dout_q;
    rsp_id_d    = rsp_id_q;
    rr_ptr_d    = rr_ptr_q;
    op_cnt_d    = op_cnt_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_dout_d  = prod_full[14:0];
      rsp_id_d    = grant;
      rr_ptr_d    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      op_cnt_d    = op_cnt_q + CNT_W'(1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_dout_q  <= '0;
      rsp_id_q    <= '0;
      rr_ptr_q    <= '0;
      op_cnt_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_dout_q  <= rsp_dout_d;
      rsp_id_q    <= rsp_id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_dout  = rsp_dout_q;
  assign rsp_id    = rsp_id_q;
  assign op_cnt    = op_cnt_q;

endmodule
